// File: rtl/rysy_bus_mem.sv
// rtl/rysy_bus_mem.sv - single-port bus memory for rysy_core with req/ready/ack handshake
//
// Purpose: word-organised on-chip RAM answering the rysy_core bus. A request is
// accepted when req and ready are both high at a rising edge. The access completes
// WAIT_STATES edges later and ack pulses for one cycle afterwards. err accompanies
// ack for out-of-range word indices.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active low
//   req    - access request
//   ready  - memory can accept a request this cycle
//   we     - 1 = write, 0 = read
//   be     - byte-lane write enables
//   addr   - byte address (low lane-select bits ignored)
//   wdata  - write data
//   rdata  - read data, held between read completions
//   ack    - one-cycle completion pulse
//   err    - out-of-range flag, valid with ack
module rysy_bus_mem #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_RDATA = 32'h00000013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  output logic                    ready,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ack,
  output logic                    err
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int LSB = $clog2(BPW);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]            WS     = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] RST_RD = DATA_WIDTH'(RESET_RDATA);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [3:0]            cnt;
  logic                  p_we;
  logic [BPW-1:0]        p_be;
  logic [31:0]           p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;

  logic                  accept;
  logic                  fire;
  logic                  a_we;
  logic [BPW-1:0]        a_be;
  logic [31:0]           a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [31:0]           idx;
  logic                  in_range;

  assign ready  = (state == S_IDLE);
  assign accept = rst && req && ready;

  // With no wait states the access happens at the accepting edge using the live
  // bus inputs; otherwise it happens at the last wait edge using the latched copy.
  assign fire = rst && ((accept && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && (cnt == 4'd0)));

  always_comb begin
    a_we    = we;
    a_be    = be;
    a_addr  = addr;
    a_wdata = wdata;
    if (state == S_WAIT) begin
      a_we    = p_we;
      a_be    = p_be;
      a_addr  = p_addr;
      a_wdata = p_wdata;
    end
  end

  assign idx      = a_addr >> LSB;
  assign in_range = (idx < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= RST_RD;
    end else begin
      ack <= fire;
      err <= fire && !in_range;
      if (fire && !a_we) begin
        rdata <= in_range ? mem[idx[AW-1:0]] : '0;
      end
      if (state == S_IDLE) begin
        if (accept && (WAIT_STATES != 0)) begin
          state <= S_WAIT;
          cnt   <= WS - 4'd1;
        end
      end else begin
        if (cnt == 4'd0) begin
          state <= S_IDLE;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // Request capture; only consumed while in WAIT, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      p_we    <= we;
      p_be    <= be;
      p_addr  <= addr;
      p_wdata <= wdata;
    end
  end

  // Array contents survive reset; fire already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (fire && a_we && in_range) begin
      for (int i = 0; i < BPW; i++) begin
        if (a_be[i]) begin
          mem[idx[AW-1:0]][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/rysy_bus_mem.md
Name: rysy_bus_mem

Overview:
- Parametrised single-port data/instruction memory that answers the rysy_core bus (addr, wdata, rdata, we, be).
- Replaces hand-driven rdata stimulus in core-level benches; also the synthesizable on-chip RAM for the core.
- Adds a req/ready/ack handshake, configurable wait states, per-lane byte writes, out-of-range error reporting and a reset-time NOP on rdata.

Parameters:
- DATA_WIDTH, 32, bus width in bits; multiple of 8.
- DEPTH, 256, number of DATA_WIDTH words.
- WAIT_STATES, 0, cycles ready stays low after each accepted request; range 0..15.
- RESET_RDATA, 32'h00000013, rdata value after reset (RISC-V NOP); truncated or zero-extended to DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- req  in  1  access request.
- ready  out  1  memory can accept a request this cycle.
- we  in  1  1 = write, 0 = read.
- be  in  DATA_WIDTH/8  byte-lane write enables.
- addr  in  32  byte address; low log2(DATA_WIDTH/8) bits ignored.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data.
- ack  out  1  one-cycle completion pulse for reads and writes.
- err  out  1  valid with ack; out-of-range access.

Behaviour:
- Reset (rst=0 at a rising edge): ready=1, ack=0, err=0, rdata=RESET_RDATA. Wait counter is cleared, pending access is dropped and no ack is issued for it. Array contents are preserved.
- Accept: request accepted at edge n when req=1 and ready=1. Inputs are sampled only at that edge and need not be held afterwards.
- FSM states:
  - IDLE: ready=1. On accept, go to WAIT if WAIT_STATES>0, otherwise stay in IDLE.
  - WAIT: ready=0, counter counts WAIT_STATES edges, then go to IDLE.
- Completion: ack=1 (and err if applicable) in the cycle after edge n+WAIT_STATES. ready returns to 1 in that same cycle.
- Throughput: with WAIT_STATES=0, ack follows accept by one cycle and back-to-back requests give one ack per cycle.
- req while ready=0 is ignored (not queued). The master must hold req until it is accepted.
- Word index = addr >> log2(DATA_WIDTH/8).
- Write:
  - Lanes with be[i]=1 are written at edge n+WAIT_STATES; other lanes are unchanged.
  - be=0 is a no-op that is still acked.
  - rdata is unchanged by writes.
- Read:
  - Array is sampled at edge n+WAIT_STATES; rdata is updated at that edge.
  - A read accepted after a write to the same word returns the new data.
- Out-of-range (index >= DEPTH): write suppressed, rdata=0, err=1 with ack.
- Hold: rdata holds its last value between read acks. err=0 whenever ack=0.
- Reset during WAIT: access is aborted and a write is not committed. ack stays 0 and ready=1 in the next cycle.
- Reset and req in the same cycle: reset wins and the request is not accepted.

Test Plan:
- Reset (DATA_WIDTH=32, DEPTH=256, WAIT_STATES=0) -> rdata=32'h00000013, ready=1, ack=0, err=0 in the first cycle after rst deasserts.
- Write addr=0x10, wdata=32'hDEADBEEF, be=4'hF, then read addr=0x10 next cycle -> two consecutive ack pulses; rdata=32'hDEADBEEF with the second ack.
- Byte lanes: write addr=0x20 wdata=32'h11223344 be=F, then wdata=32'hAABBCCDD be=4'b0101, then read -> rdata=32'h11BB33DD.
- WAIT_STATES=2: read accepted at edge n -> ready=0 for 2 cycles; ack and ready=1 in the cycle after edge n+2; a req held during wait is accepted only then.
- Out-of-range: read addr=0x400 (index 256) -> ack=1, err=1, rdata=0. Write to 0x400 then read 0x0 -> word 0 unchanged.
- Reset mid-wait (WAIT_STATES=3): write 32'hCAFEF00D to 0x8 accepted, rst=0 one cycle later -> no ack; a later read of 0x8 returns the prior value.
